// File: rtl/bp_be_fma_wb_buffer.sv
// bp_be_fma_wb_buffer: in-order writeback FIFO for FMA/IMUL results with dispatch credits and FP flag accrual.
// Ports:
//   clk_i, reset_n_i                       clock, async active-low reset
//   dispatch_v_i / ready_o                 credit consume / credits available
//   squash_v_i                             return a credit for a poisoned in-flight op
//   fma_v_i, fma_data_i, fma_fflags_i, fma_rd_i   FMA result (FP regfile)
//   imul_v_i, imul_data_i, imul_rd_i              IMUL result (integer regfile)
//   wb_v_o, wb_ready_i, wb_fp_o, wb_rd_o, wb_data_o   head-of-queue writeback port
//   fflags_o, fflags_clr_i                 sticky FP exception flags, clear on fcsr write
module bp_be_fma_wb_buffer #(
    parameter int els_p            = 4,
    parameter int dpath_width_p    = 66,
    parameter int reg_addr_width_p = 5
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        dispatch_v_i,
    output logic                        ready_o,
    input  logic                        fma_v_i,
    input  logic [dpath_width_p-1:0]    fma_data_i,
    input  logic [4:0]                  fma_fflags_i,
    input  logic [reg_addr_width_p-1:0] fma_rd_i,
    input  logic                        imul_v_i,
    input  logic [dpath_width_p-1:0]    imul_data_i,
    input  logic [reg_addr_width_p-1:0] imul_rd_i,
    input  logic                        squash_v_i,
    output logic                        wb_v_o,
    input  logic                        wb_ready_i,
    output logic                        wb_fp_o,
    output logic [reg_addr_width_p-1:0] wb_rd_o,
    output logic [dpath_width_p-1:0]    wb_data_o,
    output logic [4:0]                  fflags_o,
    input  logic                        fflags_clr_i
);
    localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w = $clog2(els_p + 1);

    typedef struct packed {
        logic                        fp;
        logic [reg_addr_width_p-1:0] rd;
        logic [dpath_width_p-1:0]    data;
        logic [4:0]                  fflags;
    } entry_t;

    entry_t             mem_q [els_p];
    entry_t             mem_d [els_p];
    logic [ptr_w-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_p1;
    logic [cnt_w-1:0]   count_q, count_d, credits_q, credits_d;
    logic [cnt_w:0]     count_sum, credits_sum;
    logic [4:0]         fflags_q, fflags_d;
    logic [1:0]         n_enq;
    logic               hs;
    entry_t             head, fma_e, imul_e;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [ptr_w-1:0] inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        head      = mem_q[rd_ptr_q];
        hs        = (count_q != '0) & wb_ready_i;
        fma_e     = {1'b1, fma_rd_i, fma_data_i, fma_fflags_i};
        imul_e    = {1'b0, imul_rd_i, imul_data_i, 5'b0};
        n_enq     = {1'b0, fma_v_i} + {1'b0, imul_v_i};
        wr_ptr_p1 = inc(wr_ptr_q);
        mem_d     = mem_q;
        // IMUL takes the older slot when both results land together.
        if (imul_v_i) mem_d[wr_ptr_q] = imul_e;
        if (fma_v_i) mem_d[imul_v_i ? wr_ptr_p1 : wr_ptr_q] = fma_e;
        wr_ptr_d    = (n_enq == 2'd2) ? inc(wr_ptr_p1) : (n_enq == 2'd1) ? wr_ptr_p1 : wr_ptr_q;
        rd_ptr_d    = hs ? inc(rd_ptr_q) : rd_ptr_q;
        count_sum   = (cnt_w+1)'(count_q) + (cnt_w+1)'(n_enq) - (cnt_w+1)'(hs);
        count_d     = count_sum[cnt_w-1:0];
        credits_sum = (cnt_w+1)'(credits_q) - (cnt_w+1)'(dispatch_v_i) + (cnt_w+1)'(hs) + (cnt_w+1)'(squash_v_i);
        credits_d   = credits_sum[cnt_w-1:0];
        // Flags accrue only when an FP result is actually written; clear loses to the head's flags.
        fflags_d    = (fflags_clr_i ? 5'b0 : fflags_q) | ((hs && head.fp) ? head.fflags : 5'b0);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            credits_q <= cnt_w'(els_p);
            fflags_q  <= '0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            credits_q <= credits_d;
            fflags_q  <= fflags_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(dispatch_v_i && credits_q == '0)) else $error("dispatch with no credits");
            assert (count_sum <= (cnt_w+1)'(els_p)) else $error("enqueue overflows buffer");
            assert (credits_sum <= (cnt_w+1)'(els_p)) else $error("credit count exceeds depth");
        end
    end

    assign ready_o   = credits_q != '0;
    assign wb_v_o    = count_q != '0;
    assign wb_fp_o   = head.fp;
    assign wb_rd_o   = head.rd;
    assign wb_data_o = head.data;
    assign fflags_o  = fflags_q;
endmodule

// File: tb/tb_bp_be_fma_wb_buffer.sv
// tb_bp_be_fma_wb_buffer: directed self-checking bench for bp_be_fma_wb_buffer.
module tb_bp_be_fma_wb_buffer;
    logic        clk_i = 0, reset_n_i = 0;
    logic        dispatch_v_i = 0, ready_o;
    logic        fma_v_i = 0, imul_v_i = 0, squash_v_i = 0;
    logic [65:0] fma_data_i = '0, imul_data_i = '0;
    logic [4:0]  fma_fflags_i = '0;
    logic [4:0]  fma_rd_i = '0, imul_rd_i = '0;
    logic        wb_v_o, wb_ready_i = 0, wb_fp_o;
    logic [4:0]  wb_rd_o;
    logic [65:0] wb_data_o;
    logic [4:0]  fflags_o;
    logic        fflags_clr_i = 0;
    int          n_chk = 0, n_fail = 0;

    bp_be_fma_wb_buffer #(.els_p(4), .dpath_width_p(66), .reg_addr_width_p(5)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .dispatch_v_i(dispatch_v_i), .ready_o(ready_o),
        .fma_v_i(fma_v_i), .fma_data_i(fma_data_i), .fma_fflags_i(fma_fflags_i), .fma_rd_i(fma_rd_i),
        .imul_v_i(imul_v_i), .imul_data_i(imul_data_i), .imul_rd_i(imul_rd_i),
        .squash_v_i(squash_v_i), .wb_v_o(wb_v_o), .wb_ready_i(wb_ready_i), .wb_fp_o(wb_fp_o),
        .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic fp, input logic [4:0] rd, input logic [65:0] data);
        chk({tag, ".v"}, 128'(wb_v_o), 128'(1));
        chk({tag, ".fp"}, 128'(wb_fp_o), 128'(fp));
        chk({tag, ".rd"}, 128'(wb_rd_o), 128'(rd));
        chk({tag, ".data"}, 128'(wb_data_o), 128'(data));
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_wb_v", 128'(wb_v_o), 128'(0));
        chk("rst_ready", 128'(ready_o), 128'(1));
        chk("rst_fflags", 128'(fflags_o), 128'(0));
        chk("rst_credits", 128'(dut.credits_q), 128'(4));
        reset_n_i = 1;
        // Four dispatches drain all credits
        dispatch_v_i = 1;
        tick(); tick(); tick();
        chk("disp3_ready", 128'(ready_o), 128'(1));
        tick();
        dispatch_v_i = 0;
        chk("disp4_ready", 128'(ready_o), 128'(0));
        chk("disp4_credits", 128'(dut.credits_q), 128'(0));
        squash_v_i = 1;
        tick();
        squash_v_i = 0;
        chk("squash_ready", 128'(ready_o), 128'(1));
        chk("squash_credits", 128'(dut.credits_q), 128'(1));
        // Simultaneous FMA + IMUL: IMUL drains first
        wb_ready_i = 1;
        fma_v_i = 1; fma_rd_i = 3; fma_data_i = 66'h1_0000_0000_0000_0001; fma_fflags_i = 5'b00001;
        imul_v_i = 1; imul_rd_i = 7; imul_data_i = 66'd42;
        tick();
        fma_v_i = 0; imul_v_i = 0;
        chk_head("pair_imul", 1'b0, 5'd7, 66'd42);
        tick();
        chk_head("pair_fma", 1'b1, 5'd3, 66'h1_0000_0000_0000_0001);
        chk("pair_fflags_pre", 128'(fflags_o), 128'(0));
        chk("pair_credits_mid", 128'(dut.credits_q), 128'(2));
        tick();
        chk("pair_fflags", 128'(fflags_o), 128'(5'b00001));
        chk("pair_empty", 128'(wb_v_o), 128'(0));
        chk("pair_credits", 128'(dut.credits_q), 128'(3));
        squash_v_i = 1;
        tick();
        squash_v_i = 0;
        chk("pair_credits_full", 128'(dut.credits_q), 128'(4));
        // Fill four entries under backpressure (write pointer wraps)
        wb_ready_i = 0;
        dispatch_v_i = 1;
        tick(); tick(); tick(); tick();
        dispatch_v_i = 0;
        imul_v_i = 1; imul_rd_i = 1; imul_data_i = 66'h11;
        fma_v_i = 1; fma_rd_i = 2; fma_data_i = 66'h22; fma_fflags_i = 5'b10000;
        tick();
        imul_rd_i = 4; imul_data_i = 66'h33;
        fma_rd_i = 5; fma_data_i = 66'h44; fma_fflags_i = 5'b00000;
        tick();
        imul_v_i = 0; fma_v_i = 0;
        for (int i = 0; i < 5; i++) begin
            chk_head("hold", 1'b0, 5'd1, 66'h11);
            chk("hold_ready", 128'(ready_o), 128'(0));
            tick();
        end
        wb_ready_i = 1;
        chk_head("pop_a", 1'b0, 5'd1, 66'h11);
        tick();
        chk_head("pop_b", 1'b1, 5'd2, 66'h22);
        chk("pop_b_fflags_pre", 128'(fflags_o), 128'(5'b00001));
        fflags_clr_i = 1;
        tick();
        fflags_clr_i = 0;
        chk("clr_accrue", 128'(fflags_o), 128'(5'b10000));
        chk_head("pop_c", 1'b0, 5'd4, 66'h33);
        tick();
        chk_head("pop_d", 1'b1, 5'd5, 66'h44);
        tick();
        chk("drain_empty", 128'(wb_v_o), 128'(0));
        chk("drain_credits", 128'(dut.credits_q), 128'(4));
        chk("drain_fflags", 128'(fflags_o), 128'(5'b10000));
        // Dispatch, squash and handshake coincide at credits=1
        wb_ready_i = 0;
        dispatch_v_i = 1;
        tick(); tick(); tick();
        dispatch_v_i = 0;
        imul_v_i = 1; imul_rd_i = 6; imul_data_i = 66'h66;
        tick();
        imul_v_i = 0;
        chk("coin_credits_pre", 128'(dut.credits_q), 128'(1));
        chk_head("coin_head", 1'b0, 5'd6, 66'h66);
        dispatch_v_i = 1; squash_v_i = 1; wb_ready_i = 1;
        tick();
        dispatch_v_i = 0; squash_v_i = 0; wb_ready_i = 0;
        chk("coin_credits", 128'(dut.credits_q), 128'(2));
        chk("coin_ready", 128'(ready_o), 128'(1));
        chk("coin_empty", 128'(wb_v_o), 128'(0));
        // Asynchronous reset with three entries queued
        imul_v_i = 1; imul_rd_i = 10; imul_data_i = 66'h0A;
        fma_v_i = 1; fma_rd_i = 11; fma_data_i = 66'h0B;
        tick();
        fma_v_i = 0; imul_v_i = 0;
        dispatch_v_i = 1;
        tick();
        dispatch_v_i = 0;
        imul_v_i = 1; imul_rd_i = 12; imul_data_i = 66'h0C;
        tick();
        imul_v_i = 0;
        chk("pre_rst_count", 128'(dut.count_q), 128'(3));
        chk_head("pre_rst_head", 1'b0, 5'd10, 66'h0A);
        #3;
        reset_n_i = 0;
        #1;
        chk("async_wb_v", 128'(wb_v_o), 128'(0));
        chk("async_ready", 128'(ready_o), 128'(1));
        chk("async_credits", 128'(dut.credits_q), 128'(4));
        chk("async_fflags", 128'(fflags_o), 128'(0));
        tick();
        reset_n_i = 1;
        dispatch_v_i = 1;
        tick();
        dispatch_v_i = 0;
        imul_v_i = 1; imul_rd_i = 9; imul_data_i = 66'h99;
        #1;
        chk("no_bypass", 128'(wb_v_o), 128'(0));
        tick();
        imul_v_i = 0;
        chk_head("post_rst", 1'b0, 5'd9, 66'h99);
        chk("post_rst_credits", 128'(dut.credits_q), 128'(3));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bp_be_fma_wb_buffer.md
Name: bp_be_fma_wb_buffer

Overview:
- Receive end of the FMA/IMUL pipe result streams.
- Buffers fire-and-forget results (the pipe has no backpressure) in one in-order FIFO, drains them through a single valid/ready writeback port to the FP or integer regfile, and accrues FP exception flags at drain time.
- Issues dispatch credits so the issue stage never launches an op the buffer cannot absorb.

Parameters:
- els_p, 4, FIFO depth and initial credit count (≥2).
- dpath_width_p, 66, result data width (FP recoded width ≥ 64).
- reg_addr_width_p, 5, destination register index width.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset; one clock, asynchronous assert, active-low.
- dispatch_v_i  in  1  issue launched one FMA-pipe op (FMA or IMUL) this cycle; consumes one credit.
- ready_o  out  1  credits available; issue may assert dispatch_v_i only when high.
- fma_v_i  in  1  FMA result valid.
- fma_data_i  in  dpath_width_p  FMA result (recoded, sp_not_dp included).
- fma_fflags_i  in  5  FMA exception flags {NV,DZ,OF,UF,NX}.
- fma_rd_i  in  reg_addr_width_p  FP destination.
- imul_v_i  in  1  IMUL result valid.
- imul_data_i  in  dpath_width_p  IMUL result.
- imul_rd_i  in  reg_addr_width_p  integer destination.
- squash_v_i  in  1  a dispatched op left the pipe poisoned; returns its credit.
- wb_v_o  out  1  head entry valid.
- wb_ready_i  in  1  regfile accepts head.
- wb_fp_o  out  1  1 = FP regfile, 0 = integer regfile.
- wb_rd_o  out  reg_addr_width_p  destination.
- wb_data_o  out  dpath_width_p  write data.
- fflags_o  out  5  sticky accrued flags.
- fflags_clr_i  in  1  clear accrued flags (fcsr write).

Behaviour:
- Reset (async, reset_n_i=0): FIFO empty, credits=els_p, fflags_o=0, wb_v_o=0, ready_o=1. Assertion mid-operation discards all entries immediately. First enqueue is allowed on the first rising edge after deassertion.
- Entry format: {fp, rd, data, fflags}. IMUL entries carry fflags=0, fp=0. FMA entries carry fp=1.
- Enqueue:
  - Up to 2 per cycle.
  - When fma_v_i and imul_v_i are high together, the IMUL entry is written first (older slot), then the FMA entry.
  - Pointers wrap modulo els_p.
  - The write takes effect at the clock edge. Enqueued data is visible on wb_* the next cycle (1-cycle minimum latency).
  - No enqueue-to-output bypass.
- Dequeue:
  - wb_v_o = (count != 0). wb_* reflect the head combinationally from storage.
  - Head entry is stable while wb_v_o && !wb_ready_i.
  - Handshake = wb_v_o & wb_ready_i; pops one entry.
  - Enqueue and dequeue in the same cycle are both honored. Count changes by enqueues minus pop.
- Credits:
  - Counter width $clog2(els_p+1).
  - Next value = credits − dispatch_v_i + handshake + squash_v_i. All three may coincide.
  - ready_o = (credits != 0).
  - Invariant: credits + in-flight ops + count == els_p.
- Violations:
  - dispatch_v_i with credits==0 → simulation assertion error.
  - Enqueue that would exceed els_p → simulation assertion error.
  - Credit count exceeding els_p → simulation assertion error.
- fflags:
  - Accrue on handshake of an fp entry: fflags_o <= (fflags_clr_i ? 0 : fflags_o) | head.fflags.
  - Clear and accrue in the same cycle → result is the head flags only.
  - Flags never accrue at enqueue, so squashed or unwritten results never set fcsr.
- No flush port: anything that reaches the buffer is already architecturally committed past poison.

Test Plan:
- Reset → wb_v_o=0, ready_o=1, fflags_o=0, credits=4. Four dispatches → ready_o=0 after the 4th. Then 1 squash_v_i → ready_o=1.
- fma_v_i (rd=3, data=0x1_0000_0000_0000_0001, fflags=5'b00001) and imul_v_i (rd=7, data=42) in the same cycle, wb_ready_i=1 → IMUL drains first (wb_fp_o=0, rd 7, 42), FMA drains next cycle (wb_fp_o=1, rd 3). After the FMA handshake, fflags_o=5'b00001.
- Hold wb_ready_i=0 for 5 cycles with 4 entries queued → wb_* constant and ready_o=0. Release → 4 consecutive pops in order, credits back to 4.
- Head FMA with fflags=5'b10000, fflags_o=5'b00001, fflags_clr_i=1 on the handshake cycle → fflags_o=5'b10000.
- In one cycle: dispatch_v_i, squash_v_i and handshake, starting at credits=1 → credits=2.
- Assert reset_n_i low mid-cycle with 3 entries queued → wb_v_o drops to 0 immediately (asynchronously) and ready_o=1. After release, a new enqueue appears after 1 cycle.
